uart_recv: RTL and testbench



---
 rtl/uart_recv.sv | 137 +++++++++++++
 tb/tb_uart_recv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// ============================================================================
// Module   : uart_recv
// Purpose  : 8N1 UART receiver with start-glitch rejection and framing-error flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;

  localparam logic [15:0] C_BIT_LAST  = 16'(BPS_CNT - 1);
  localparam logic [15:0] C_HALF_LAST = 16'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rx1_q, rx2_q, rx3_q;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        w_fall;

  assign w_fall = rx3_q & ~rx2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx1_q     <= 1'b1;
      rx2_q     <= 1'b1;
      rx3_q     <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx1_q     <= uart_rxd;
      rx2_q     <= rx1_q;
      rx3_q     <= rx2_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_fall) state_d = S_START;
      end
      S_START: begin
        // Line must still be low at mid-start-bit, otherwise it was a glitch.
        if (clk_cnt_q == C_HALF_LAST) begin
          if (rx2_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (clk_cnt_q == C_BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == C_BIT_LAST) begin
          if (rx2_q) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) clk_cnt_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  assign data      = data_q;
  assign uart_done = done_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_recv.sv
// ============================================================================
// Module   : tb_uart_recv
// Purpose  : Scoreboard bench for uart_recv with B=16, H=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_recv;

  localparam int B   = 16;
  localparam int H   = 8;
  localparam int LAT = 2 + H + 9 * B;  // T0 -> result pulse

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] data;
  logic       uart_done;
  logic       frame_err;
  logic       busy;

  uart_recv #(.CLK_FREQ(16), .UART_BPS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .data      (data),
    .uart_done (uart_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_err;
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       q[$];
  exp_t       e_m;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] echo_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_done || frame_err) begin
        chk("done_and_err_together", {31'd0, uart_done & frame_err}, 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e_m = q.pop_front();
          chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e_m.is_err});
          chk("data", {24'd0, data}, {24'd0, e_m.d});
          chk("pulse_cycle", cyc, e_m.due);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        e_m = q.pop_front();
        chk("missing_pulse", 32'd0, 32'd1);
      end
      if (uart_done) echo_byte = data;
    end
  end

  task automatic drive(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Serialize one frame; 'expect_b' is what the reference says must appear.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [7:0] expect_b,
                            input int hold);
    int t0;
    t0 = cyc + 1;
    if (stop) begin
      q.push_back('{is_err: 1'b0, d: expect_b, due: t0 + LAT});
      last_good = expect_b;
    end else begin
      q.push_back('{is_err: 1'b1, d: last_good, due: t0 + LAT});
    end
    drive(1'b0, B);
    for (int i = 0; i < 8; i++) drive(b[i], B);
    drive(stop, B);
    if (!stop) begin
      drive(1'b0, hold);
      chk("busy_held_in_break", {31'd0, busy}, 32'd1);
      drive(1'b1, 5);
      chk("busy_after_break", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic glitch(input int len);
    int t0;
    t0 = cyc + 1;
    for (int k = 0; k < 14; k++) begin
      uart_rxd = (k < len) ? 1'b0 : 1'b1;
      if (cyc == t0 + 3) chk("busy_during_glitch", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("busy_after_glitch", {31'd0, busy}, 32'd0);
    chk("data_after_glitch", {24'd0, data}, {24'd0, last_good});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_done", {31'd0, uart_done}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         r;
    rst      = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(8'h55, 1'b1, 8'h55, 0);
    drive(1'b1, 3);
    send_frame(8'hA3, 1'b1, 8'hA3, 0);
    send_frame(8'h0F, 1'b1, 8'h0F, 0);
    drive(1'b1, 3);
    glitch(5);
    send_frame(8'h3C, 1'b0, 8'h00, 40);
    drive(1'b1, 3);

    // Abort a frame with reset partway through its data bits.
    drive(1'b0, B);
    drive(1'b1, B);
    drive(1'b0, B);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_outputs();
    rst       = 1'b0;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    chk("busy_after_release", {31'd0, busy}, 32'd0);
    send_frame(8'h7E, 1'b1, 8'h7E, 0);
    drive(1'b1, 4);

    // Loopback: the byte reported by uart_done is re-serialized back in.
    send_frame(8'hC6, 1'b1, 8'hC6, 0);
    drive(1'b1, 3);
    rb = echo_byte;
    send_frame(rb, 1'b1, 8'hC6, 0);
    drive(1'b1, 3);

    for (int n = 0; n < 30; n++) begin
      r  = $urandom_range(0, 9);
      rb = 8'($urandom_range(0, 255));
      if (r < 2) begin
        glitch($urandom_range(1, 6));
      end else if (r < 4) begin
        send_frame(rb, 1'b0, rb, $urandom_range(0, 40));
      end else begin
        send_frame(rb, 1'b1, rb, 0);
      end
      drive(1'b1, $urandom_range(0, 5));
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
